// File: rtl/simplebus_ram_follower.sv
// Simplebus follower backing a 2**ADDR_BITS-byte RAM window; read data and dataValid appear WAIT_CYCLES+1 cycles after ADDR_LO.
// Writes wait on the leader's dv_in indefinitely; misses sit in SKIP until dv_in or SKIP_TIMEOUT, never driving the bus.
module simplebus_ram_follower #(
    parameter logic [15:0] BASE_ADDR    = 16'h0400,
    parameter int          ADDR_BITS    = 8,
    parameter int          WAIT_CYCLES  = 2,
    parameter int          SKIP_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       read,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       dv_in,
    output logic       dv_out,
    output logic       dv_oe,
    output logic       busy
);

    localparam int                SKIP_W    = $clog2(SKIP_TIMEOUT + 1);
    localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_READ_WAIT,
        S_READ_DRIVE,
        S_WRITE_WAIT,
        S_SKIP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         addr;
    logic [15:0]         addr_nxt;
    logic [15:0]         addr_cur;
    logic [3:0]          wait_cnt;
    logic [3:0]          wait_cnt_nxt;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [SKIP_W-1:0]   skip_cnt_nxt;
    logic                hit;
    logic                ram_we;
    logic                ram_rd;
    logic [ADDR_BITS-1:0] ram_idx;
    logic [7:0]          ram [0:(1<<ADDR_BITS)-1];

    // In ADDR_LO the low byte is still on the bus, so decode the live value.
    always_comb begin
        addr_cur = (state == S_ADDR_LO) ? {addr[15:8], address} : addr;
        hit      = (addr_cur[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
        ram_idx  = addr_cur[ADDR_BITS-1:0];
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        wait_cnt_nxt = wait_cnt;
        skip_cnt_nxt = skip_cnt;
        ram_we       = 1'b0;
        ram_rd       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt  = {address, addr[7:0]};
                    state_nxt = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                addr_nxt = addr_cur;
                if (!hit) begin
                    skip_cnt_nxt = '0;
                    state_nxt    = S_SKIP;
                end else if (read) begin
                    if (WAIT_CYCLES == 0) begin
                        ram_rd    = 1'b1;
                        state_nxt = S_READ_DRIVE;
                    end else begin
                        wait_cnt_nxt = WAIT_LOAD;
                        state_nxt    = S_READ_WAIT;
                    end
                end else begin
                    state_nxt = S_WRITE_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    ram_rd    = 1'b1;
                    state_nxt = S_READ_DRIVE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_READ_DRIVE: begin
                state_nxt = S_IDLE;
            end
            S_WRITE_WAIT: begin
                if (dv_in) begin
                    ram_we    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_SKIP: begin
                if (dv_in || skip_cnt == SKIP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    skip_cnt_nxt = skip_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus-facing outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            addr     <= '0;
            wait_cnt <= '0;
            skip_cnt <= '0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
            dv_oe    <= 1'b0;
            dv_out   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            wait_cnt <= wait_cnt_nxt;
            skip_cnt <= skip_cnt_nxt;
            data_oe  <= (state_nxt == S_READ_DRIVE);
            dv_oe    <= (state_nxt == S_READ_DRIVE);
            dv_out   <= (state_nxt == S_READ_DRIVE);
            busy     <= (state_nxt != S_IDLE);
            if (ram_rd) begin
                data_out <= ram[ram_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && ram_we) begin
            ram[ram_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_simplebus_ram_follower.sv
// Bench: two followers (WAIT_CYCLES=2 and 0) on one bus, checked every cycle against a timeline model.
module tb_simplebus_ram_follower;

    localparam int SKIP_TO = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       read = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       dv_in = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       doe_a, doe_b, dvo_a, dvo_b, dvoe_a, dvoe_b, busy_a, busy_b;

    simplebus_ram_follower #(.BASE_ADDR(16'h0400), .ADDR_BITS(8), .WAIT_CYCLES(2), .SKIP_TIMEOUT(SKIP_TO)) dut_w2 (
        .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
        .data_in(data_in), .data_out(dout_a), .data_oe(doe_a), .dv_in(dv_in),
        .dv_out(dvo_a), .dv_oe(dvoe_a), .busy(busy_a)
    );

    simplebus_ram_follower #(.BASE_ADDR(16'h0400), .ADDR_BITS(8), .WAIT_CYCLES(0), .SKIP_TIMEOUT(SKIP_TO)) dut_w0 (
        .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
        .data_in(data_in), .data_out(dout_b), .data_oe(doe_b), .dv_in(dv_in),
        .dv_out(dvo_b), .dv_oe(dvoe_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: expected busy window and drive cycle per follower, plus its RAM image.
    int         busy_lo [2] = '{-10, -10};
    int         busy_hi [2] = '{-20, -20};
    int         drv_cyc [2] = '{-10, -10};
    logic [7:0] drv_dat [2];
    logic [7:0] mem [2][256];
    int         rst_cyc = -10;
    int         addr_lo_cyc = 0;
    bit         chk_en = 1'b0;

    // Observation counters, written only by the monitor.
    int         oe_cnt [2] = '{0, 0};
    int         busy_cnt [2] = '{0, 0};
    int         dv_seen_cyc [2] = '{-1, -1};
    logic [7:0] dv_seen_dat [2];

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic b, oe, dv, dvoe;
            logic [7:0] d;
            logic act_exp, busy_exp;
            b    = (i == 0) ? busy_a : busy_b;
            oe   = (i == 0) ? doe_a  : doe_b;
            dv   = (i == 0) ? dvo_a  : dvo_b;
            dvoe = (i == 0) ? dvoe_a : dvoe_b;
            d    = (i == 0) ? dout_a : dout_b;
            if (oe === 1'b1) oe_cnt[i] = oe_cnt[i] + 1;
            if (b === 1'b1) busy_cnt[i] = busy_cnt[i] + 1;
            if (dv === 1'b1) begin
                dv_seen_cyc[i] = cyc;
                dv_seen_dat[i] = d;
            end
            if (chk_en) begin
                act_exp  = (cyc == drv_cyc[i]);
                busy_exp = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
                check($sformatf("busy[%0d]", i), {31'd0, b}, {31'd0, busy_exp});
                check($sformatf("dv_out[%0d]", i), {31'd0, dv}, {31'd0, act_exp});
                check($sformatf("dv_oe[%0d]", i), {31'd0, dvoe}, {31'd0, act_exp});
                check($sformatf("data_oe[%0d]", i), {31'd0, oe}, {31'd0, act_exp});
                if (act_exp) check($sformatf("data_out[%0d]", i), {24'd0, d}, {24'd0, drv_dat[i]});
                if (cyc == rst_cyc + 1) check($sformatf("reset_dout[%0d]", i), {24'd0, d}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input bit rd, input bit hold);
        start = 1'b1; address = a[15:8]; read = 1'b0;
        tick();
        start = hold; address = a[7:0]; read = rd;
        addr_lo_cyc = cyc;
        tick();
        address = 8'h00; read = 1'b0;
    endtask

    // Hit read; optional reset asserted rst_off cycles after start.
    task automatic do_read(input logic [15:0] a, input int rst_off);
        int s;
        s = cyc;
        for (int i = 0; i < 2; i++) begin
            busy_lo[i] = s + 1;
            busy_hi[i] = s + wc(i) + 2;
            drv_cyc[i] = s + wc(i) + 2;
            drv_dat[i] = mem[i][a[7:0]];
        end
        send_addr(a, 1'b1, 1'b0);
        if (rst_off == 2) begin
            rst_cyc = cyc;
            for (int i = 0; i < 2; i++) begin
                if (busy_hi[i] > rst_cyc) busy_hi[i] = rst_cyc;
                if (drv_cyc[i] > rst_cyc) drv_cyc[i] = -10;
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            repeat (2) tick();
        end else begin
            repeat (3) tick();
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap, input bit hold);
        int s;
        s = cyc;
        for (int i = 0; i < 2; i++) begin
            busy_lo[i] = s + 1;
            busy_hi[i] = s + 2 + gap;
            drv_cyc[i] = -10;
        end
        send_addr(a, 1'b0, hold);
        repeat (gap) tick();
        dv_in = 1'b1; data_in = d;
        tick();
        dv_in = 1'b0; data_in = 8'h00; start = 1'b0;
        for (int i = 0; i < 2; i++) mem[i][a[7:0]] = d;
    endtask

    // Miss; gap<0 means no dv_in, so the follower must time out.
    task automatic do_miss(input logic [15:0] a, input bit rd, input int gap);
        int s;
        s = cyc;
        for (int i = 0; i < 2; i++) begin
            busy_lo[i] = s + 1;
            busy_hi[i] = (gap >= 0) ? s + 2 + gap : s + 1 + SKIP_TO;
            drv_cyc[i] = -10;
        end
        send_addr(a, rd, 1'b0);
        if (gap >= 0) begin
            repeat (gap) tick();
            dv_in = 1'b1; data_in = 8'h77;
            tick();
            dv_in = 1'b0; data_in = 8'h00;
        end else begin
            repeat (SKIP_TO) tick();
        end
    endtask

    initial begin
        int oe0, oe1, bc0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_data_oe", {31'd0, doe_a}, 32'd0);
        check("rst_dv_oe", {31'd0, dvoe_a}, 32'd0);
        check("rst_dv_out", {31'd0, dvo_a}, 32'd0);
        check("rst_data_out", {24'd0, dout_a}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // 1: write then read with two wait states
        do_write(16'h0406, 8'hDC, 1, 1'b0);
        do_read(16'h0406, -1);
        check("t1_latency", 32'(dv_seen_cyc[0] - addr_lo_cyc), 32'd3);
        check("t1_data", {24'd0, dv_seen_dat[0]}, 32'h0000_00DC);

        // 2: zero-wait follower, single-cycle drive
        do_write(16'h0407, 8'hAB, 0, 1'b0);
        do_write(16'h04FF, 8'h3C, 2, 1'b0);
        oe1 = oe_cnt[1];
        do_read(16'h0407, -1);
        check("t2_latency", 32'(dv_seen_cyc[1] - addr_lo_cyc), 32'd1);
        check("t2_data", {24'd0, dv_seen_dat[1]}, 32'h0000_00AB);
        check("t2_oe_cycles", 32'(oe_cnt[1] - oe1), 32'd1);

        // 3: miss ended by dv_in; nothing driven, RAM untouched
        oe0 = oe_cnt[0]; oe1 = oe_cnt[1];
        do_miss(16'h0506, 1'b0, 3);
        check("t3_idle_after_dv", {31'd0, busy_a}, 32'd0);
        check("t3_no_drive", 32'((oe_cnt[0] - oe0) + (oe_cnt[1] - oe1)), 32'd0);
        do_read(16'h0406, -1);
        check("t3_ram_kept", {24'd0, dv_seen_dat[0]}, 32'h0000_00DC);

        // 4: miss with no dv_in times out, then an immediate hit read
        bc0 = busy_cnt[0];
        do_miss(16'h0510, 1'b1, -1);
        check("t4_busy_cycles", 32'(busy_cnt[0] - bc0), 32'd65);
        do_read(16'h04FF, -1);
        check("t4_data", {24'd0, dv_seen_dat[0]}, 32'h0000_003C);

        // 5: reset in READ_WAIT aborts the read without touching RAM
        oe0 = oe_cnt[0];
        do_read(16'h0406, 2);
        check("t5_aborted", 32'(oe_cnt[0] - oe0), 32'd0);
        do_read(16'h0406, -1);
        check("t5_data", {24'd0, dv_seen_dat[0]}, 32'h0000_00DC);

        // 6: start held through WRITE_WAIT and the return edge is ignored
        do_write(16'h0406, 8'hF1, 3, 1'b1);
        check("t6_no_restart", {31'd0, busy_a}, 32'd0);
        tick();
        do_read(16'h0406, -1);
        check("t6_data", {24'd0, dv_seen_dat[0]}, 32'h0000_00F1);
        check("t6_data_w0", {24'd0, dv_seen_dat[1]}, 32'h0000_00F1);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
